cfg_chain_loader: RTL and testbench

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_loader.sv | 139 +++++++++++++
 tb/tb_cfg_chain_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: shifts a parallel configuration image into a serial
// configuration chain (MSB first) and can optionally read it back. The readback
// recirculates the chain and compares each bit against the latched image.
//
// Ports:
//   clk, rst       - clock (also clocks the chain); synchronous active-high reset
//   start          - load request, sampled only in IDLE
//   verify_en      - request a readback/compare pass after the load (sampled with start)
//   frame          - configuration image; bit CHAIN_LEN-1 ends up in the last chain stage
//   busy, done     - status; done is a one-cycle completion pulse
//   error          - sticky readback mismatch flag
//   err_index      - bit position of the first mismatch
//   cfg_in, cfg_en - serial data and shift enable towards the chain
//   cfg_out        - serial data returning from the chain
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 18,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 verify_en,
    input  logic [CHAIN_LEN-1:0] frame,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     err_index,
    output logic                 cfg_in,
    output logic                 cfg_en,
    input  logic                 cfg_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic                 ver_q, ver_d;
    logic                 error_q, error_d;
    logic [CNT_W-1:0]     err_index_q, err_index_d;

    // The shadow register rotates left once per shift, so its MSB is always the
    // bit for the current position and after a full pass the image is restored.
    logic [CHAIN_LEN-1:0] shadow_rot;
    assign shadow_rot = {shadow_q[CHAIN_LEN-2:0], shadow_q[CHAIN_LEN-1]};

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        ver_d       = ver_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d    = frame;
                    ver_d       = verify_en;
                    cnt_d       = '0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                shadow_d = shadow_rot;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ver_q ? S_VERIFY : S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VERIFY: begin
                shadow_d = shadow_rot;
                // Only the first mismatch is recorded.
                if ((cfg_out != shadow_q[CHAIN_LEN-1]) && !error_q) begin
                    error_d     = 1'b1;
                    err_index_d = cnt_q;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            ver_q       <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            ver_q       <= ver_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    // Status decoded straight from the state register
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cfg_en    = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign error     = error_q;
    assign err_index = err_index_q;

    // Serial data: image MSB-first in LOAD, chain recirculation in VERIFY
    always_comb begin
        cfg_in = 1'b0;
        if (state_q == S_LOAD) begin
            cfg_in = shadow_q[CHAIN_LEN-1];
        end else if (state_q == S_VERIFY) begin
            cfg_in = cfg_out;
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader with an 18-stage chain model.
module tb_cfg_chain_loader;

    localparam int unsigned L = 18;
    localparam int unsigned W = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          verify_en = 1'b0;
    logic [L-1:0]  frame = '0;
    logic          busy, done, error, cfg_in, cfg_en, cfg_out;
    logic [W-1:0]  err_index;

    int n_chk = 0;
    int n_fail = 0;

    cfg_chain_loader #(.CHAIN_LEN(L), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .verify_en(verify_en),
        .frame(frame), .busy(busy), .done(done), .error(error),
        .err_index(err_index), .cfg_in(cfg_in), .cfg_en(cfg_en),
        .cfg_out(cfg_out)
    );

    always #5 clk = ~clk;

    // Chain model: shifts toward the MSB; last stage drives cfg_out.
    logic [L-1:0] chain = '0;
    logic         fault_on = 1'b0;
    int           en_seen = 0;
    always @(posedge clk) begin
        if (cfg_en) chain <= {chain[L-2:0], cfg_in};
        if (rst || !busy) en_seen <= 0;
        else if (cfg_en) en_seen <= en_seen + 1;
    end
    // Fault: the 7th bit returned during readback is inverted.
    assign cfg_out = chain[L-1] ^ (fault_on && (en_seen == L + 6));

    typedef struct {
        logic [L-1:0] frame;
        logic         ver;
        logic         fault;
        logic         glitch;
        int           exp_done;
        logic         exp_err;
        logic [W-1:0] exp_idx;
        logic [L-1:0] exp_chain;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete operation from a table entry, checked after it settles in IDLE.
    task automatic run_op(input int i);
        vec_t         v;
        int           done_cnt, done_k, en_cnt, busy_bad;
        logic [L-1:0] stream;
        v = vecs[i];
        done_cnt = 0; done_k = 0; en_cnt = 0; busy_bad = 0; stream = '0;
        @(negedge clk);
        frame = v.frame; verify_en = v.ver; fault_on = v.fault; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            if (v.glitch && k == 4) begin
                start = 1'b1; frame = ~v.frame; verify_en = ~v.ver;
            end else begin
                start = 1'b0;
            end
            if (cfg_en) begin
                en_cnt++;
                if (k <= L) stream = {stream[L-2:0], cfg_in};
            end
            if (done) begin done_cnt++; done_k = k; end
            if (k <= v.exp_done && !busy) busy_bad++;
            if (k == v.exp_done + 1 && busy) busy_bad++;
            if (done_k != 0 && k >= done_k + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d done_cycle", i), 64'(done_k), 64'(v.exp_done));
        chk($sformatf("v%0d done_pulses", i), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d cfg_en_cycles", i), 64'(en_cnt), 64'(v.ver ? 2*L : L));
        chk($sformatf("v%0d cfg_in_stream", i), 64'(stream), 64'(v.frame));
        chk($sformatf("v%0d busy_window", i), 64'(busy_bad), 64'd0);
        chk($sformatf("v%0d error", i), 64'(error), 64'(v.exp_err));
        chk($sformatf("v%0d err_index", i), 64'(err_index), 64'(v.exp_idx));
        chk($sformatf("v%0d chain", i), 64'(chain), 64'(v.exp_chain));
    endtask

    initial begin
        //          frame      ver   fault glitch done err   idx   chain
        vecs[0] = '{18'h2A5C3, 1'b0, 1'b0, 1'b0, 19, 1'b0, 6'd0, 18'h2A5C3};
        vecs[1] = '{18'h3FFFF, 1'b1, 1'b0, 1'b0, 37, 1'b0, 6'd0, 18'h3FFFF};
        vecs[2] = '{18'h2A5C3, 1'b1, 1'b1, 1'b0, 37, 1'b1, 6'd6, 18'h2ADC3};
        vecs[3] = '{18'h00001, 1'b0, 1'b0, 1'b0, 19, 1'b0, 6'd0, 18'h00001};
        vecs[4] = '{18'h3FFFF, 1'b1, 1'b1, 1'b0, 37, 1'b1, 6'd6, 18'h3F7FF};
        vecs[5] = '{18'h15A5A, 1'b1, 1'b0, 1'b1, 37, 1'b0, 6'd0, 18'h15A5A};
        vecs[6] = '{18'h20001, 1'b1, 1'b0, 1'b0, 37, 1'b0, 6'd0, 18'h20001};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst cfg_en", 64'(cfg_en), 64'd0);
        chk("rst cfg_in", 64'(cfg_in), 64'd0);
        chk("rst error", 64'(error), 64'd0);
        chk("rst err_index", 64'(err_index), 64'd0);
        rst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 7; i++) run_op(i);

        // Reset mid-LOAD, then a clean full load
        @(negedge clk);
        frame = 18'h2A5C3; verify_en = 1'b0; fault_on = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst cfg_en", 64'(cfg_en), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst cfg_in", 64'(cfg_in), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(0);

        // Reset wins over start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; frame = 18'h3FFFF;
        @(negedge clk);
        chk("rst_prio busy", 64'(busy), 64'd0);
        chk("rst_prio cfg_en", 64'(cfg_en), 64'd0);
        rst = 1'b0; start = 1'b0;

        // Back-to-back with start held high
        begin
            int n_done, first_k, last_k, gap_bad, wide_bad;
            logic prev_done;
            n_done = 0; first_k = 0; last_k = 0; gap_bad = 0; wide_bad = 0; prev_done = 1'b0;
            @(negedge clk);
            frame = 18'h0F0F0; verify_en = 1'b0; start = 1'b1;
            for (int k = 1; k <= 62; k++) begin
                @(negedge clk);
                if (done) begin
                    if (prev_done) wide_bad++;
                    if (n_done == 0) first_k = k;
                    else if (k - last_k != L + 2) gap_bad++;
                    last_k = k;
                    n_done++;
                end
                prev_done = done;
            end
            start = 1'b0;
            chk("b2b done_count", 64'(n_done), 64'd3);
            chk("b2b first_done", 64'(first_k), 64'(L + 1));
            chk("b2b spacing", 64'(gap_bad), 64'd0);
            chk("b2b pulse_width", 64'(wide_bad), 64'd0);
            repeat (25) @(negedge clk);
            chk("b2b idle busy", 64'(busy), 64'd0);
            chk("b2b chain", 64'(chain), 64'(18'h0F0F0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
